mem_responder: RTL

Word-addressed memory responder at the far end of the CPU's MAR/MDR memory interface. It answers instruction fetches and data/stack reads and writes issued by the multicycle CPU controller. It latches a request, inserts a configurable number of wait states, performs the access, then pulses ready for one cycle with read data and an error flag.

---
 rtl/mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder for the CPU MAR/MDR interface.
// Accepts a request, waits WAIT_CYCLES, performs the access, then pulses ready.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mdr_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // state | meaning
  // IDLE  | waiting for req; request fields latched on acceptance
  // WAIT  | counting wait states; access on the edge where cnt==1
  // RESP  | ready high for this single cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic [15:0] mdr_out_q, mdr_out_d;
  logic        err_q, err_d;

  logic [15:0] mem [DEPTH];

  logic          acc_fire;
  logic          acc_we;
  logic [15:0]   acc_addr;
  logic [15:0]   acc_data;
  logic          acc_in_range;
  logic [AW-1:0] acc_idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    acc_fire = 1'b0;
    acc_addr = addr_q;
    acc_we   = we_q;
    acc_data = data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = mar;
          we_d   = we;
          data_d = mdr_in;
          // With no wait states the access uses the live inputs on the acceptance edge.
          if (WAIT_CYCLES == 0) begin
            acc_fire = 1'b1;
            acc_addr = mar;
            acc_we   = we;
            acc_data = mdr_in;
            state_d  = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_fire = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Full 16-bit compare so out-of-range addresses never alias into storage.
  assign acc_in_range = ({16'h0000, acc_addr} < 32'(DEPTH));
  assign acc_idx      = acc_addr[AW-1:0];

  always_comb begin
    mdr_out_d = mdr_out_q;
    err_d     = err_q;
    if (acc_fire) begin
      err_d = ~acc_in_range;
      if (!acc_we) mdr_out_d = acc_in_range ? mem[acc_idx] : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      we_q      <= 1'b0;
      mdr_out_q <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      mdr_out_q <= mdr_out_d;
      err_q     <= err_d;
    end
  end

  // Storage is not reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && acc_fire && acc_we && acc_in_range) mem[acc_idx] <= acc_data;
  end

  assign mdr_out = mdr_out_q;
  assign err     = err_q;
  assign ready   = (state_q == S_RESP);
  assign busy    = (state_q != S_IDLE);

endmodule
